// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   access_size_e : core access-size encoding driven on ByteAccessM
//   OFF_*         : MMIO register offsets within the 16-byte window
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } access_size_e;

    localparam logic [3:0] OFF_GPIO   = 4'h0;
    localparam logic [3:0] OFF_CYCLE  = 4'h4;
    localparam logic [3:0] OFF_STORES = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Store lane decoder (purely combinational).
//   size_i     : access size
//   addr_lo_i  : byte offset within the word (AddrM[1:0])
//   wdata_i    : right-justified store data
//   lane_en_o  : per-byte write enables, all zero when the access is misaligned
//   wdata_o    : store data replicated onto every lane it may land in
//   misalign_o : access is illegal for its size (reserved size is always illegal)
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  access_size_e size_i,
    input  logic [1:0]   addr_lo_i,
    input  logic [31:0]  wdata_i,
    output logic [3:0]   lane_en_o,
    output logic [31:0]  wdata_o,
    output logic         misalign_o
);

    always_comb begin
        lane_en_o  = 4'b0000;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_BYTE: begin
                lane_en_o = 4'b0001 << addr_lo_i;
                wdata_o   = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                if (addr_lo_i[0]) begin
                    misalign_o = 1'b1;
                end else begin
                    lane_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                end
            end
            SZ_WORD: begin
                if (addr_lo_i != 2'b00) begin
                    misalign_o = 1'b1;
                end else begin
                    lane_en_o = 4'b1111;
                end
            end
            SZ_RSVD: begin
                misalign_o = 1'b1;
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data port responder: word-organised RAM with byte-lane stores plus a
// 16-byte MMIO window (GPIO, cycle counter, store counter, sticky error status).
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   AddrM       : byte address
//   WriteDataM  : right-justified store data
//   MemWriteM   : store request
//   ByteAccessM : access size (00 byte, 01 half, 10 word, 11 reserved)
//   ReadData    : aligned word at AddrM, combinational
//   GpioOut     : GPIO output register
//   MisalignErr : sticky illegal-store flag (STATUS[0])
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [1:0]  ByteAccessM,
    output logic [31:0] ReadData,
    output logic [31:0] GpioOut,
    output logic        MisalignErr
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0] ram_q [DEPTH_WORDS];

    access_size_e size;
    logic [AW-1:0] ram_idx;
    logic          is_mmio;
    logic [1:0]    reg_sel;
    logic [3:0]    lane_en;
    logic [31:0]   lane_wdata;
    logic          misalign;

    logic [31:0] gpio_q, gpio_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] stores_q, stores_d;
    logic        status_q, status_d;

    logic ram_we;
    logic mmio_word_we;
    logic err_set;
    logic err_clr;

    assign size    = access_size_e'(ByteAccessM);
    assign ram_idx = AddrM[2 +: AW];  // out-of-range addresses alias
    assign is_mmio = (AddrM[31:4] == MMIO_BASE[31:4]);
    assign reg_sel = AddrM[3:2];

    dmem_lane_ctrl u_lane_ctrl (
        .size_i     (size),
        .addr_lo_i  (AddrM[1:0]),
        .wdata_i    (WriteDataM),
        .lane_en_o  (lane_en),
        .wdata_o    (lane_wdata),
        .misalign_o (misalign)
    );

    always_comb begin
        ram_we       = MemWriteM && !is_mmio && !misalign;
        mmio_word_we = MemWriteM && is_mmio && !misalign && (size == SZ_WORD);
        // Sub-word MMIO stores are illegal even when naturally aligned.
        err_set      = MemWriteM && (misalign || (is_mmio && size != SZ_WORD));
        err_clr      = mmio_word_we && (reg_sel == OFF_STATUS[3:2]) && WriteDataM[0];

        cycle_d  = cycle_q + 32'd1;
        gpio_d   = gpio_q;
        stores_d = stores_q;
        if (mmio_word_we && (reg_sel == OFF_GPIO[3:2])) begin
            gpio_d = WriteDataM;
        end
        if (ram_we && (stores_q != 32'hFFFF_FFFF)) begin
            stores_d = stores_q + 32'd1;
        end
        // Set has priority over a W1C clear in the same cycle.
        status_d = err_set | (status_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q   <= '0;
            cycle_q  <= '0;
            stores_q <= '0;
            status_q <= 1'b0;
        end else begin
            gpio_q   <= gpio_d;
            cycle_q  <= cycle_d;
            stores_q <= stores_d;
            status_q <= status_d;
        end
    end

    // RAM is never cleared; the reset branch only drops a store coinciding with reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    ram_q[ram_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        ReadData = ram_q[ram_idx];
        if (is_mmio) begin
            unique case (reg_sel)
                OFF_GPIO[3:2]:   ReadData = gpio_q;
                OFF_CYCLE[3:2]:  ReadData = cycle_q;
                OFF_STORES[3:2]: ReadData = stores_q;
                OFF_STATUS[3:2]: ReadData = {31'b0, status_q};
                default:         ReadData = '0;
            endcase
        end
    end

    assign GpioOut     = gpio_q;
    assign MisalignErr = status_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic        MemWriteM;
    logic [1:0]  ByteAccessM;
    logic [31:0] ReadData;
    logic [31:0] GpioOut;
    logic        MisalignErr;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] c1;
    logic [31:0] c2;

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (BASE),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .AddrM       (AddrM),
        .WriteDataM  (WriteDataM),
        .MemWriteM   (MemWriteM),
        .ByteAccessM (ByteAccessM),
        .ReadData    (ReadData),
        .GpioOut     (GpioOut),
        .MisalignErr (MisalignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One store, driven after a falling edge and committed at the next rising edge.
    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        AddrM       = a;
        WriteDataM  = d;
        ByteAccessM = sz;
        MemWriteM   = 1'b1;
        @(negedge clk);
        MemWriteM   = 1'b0;
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        AddrM = a;
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        AddrM       = '0;
        WriteDataM  = '0;
        MemWriteM   = 1'b0;
        ByteAccessM = 2'b10;
        #22;
        chk("rst_gpio", GpioOut, 32'h0);
        chk("rst_err", {31'b0, MisalignErr}, 32'h0);
        rd(BASE + 32'h4);  chk("rst_cycle", ReadData, 32'h0);
        rd(BASE + 32'h8);  chk("rst_stores", ReadData, 32'h0);
        rd(BASE + 32'hC);  chk("rst_status", ReadData, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Word store and read-back.
        st(32'h100, 32'hDEAD_BEEF, 2'b10);
        rd(32'h100);       chk("word_rd", ReadData, 32'hDEAD_BEEF);
        rd(BASE + 32'h8);  chk("stores_1", ReadData, 32'd1);

        // Byte and half merges.
        st(32'h101, 32'h0000_00AA, 2'b00);
        rd(32'h100);       chk("byte_merge", ReadData, 32'hDEAD_AAEF);
        st(32'h102, 32'hFFFF_1234, 2'b01);
        rd(32'h100);       chk("half_merge", ReadData, 32'h1234_AAEF);
        rd(BASE + 32'h8);  chk("stores_3", ReadData, 32'd3);

        // Misaligned stores write nothing and set the sticky flag.
        st(32'h103, 32'h0000_FFFF, 2'b01);
        rd(32'h100);       chk("mis_half_ram", ReadData, 32'h1234_AAEF);
        chk("mis_half_err", {31'b0, MisalignErr}, 32'h1);
        st(32'h102, 32'h0000_0000, 2'b10);
        rd(32'h100);       chk("mis_word_ram", ReadData, 32'h1234_AAEF);
        st(32'h100, 32'h0, 2'b11);
        rd(32'h100);       chk("rsvd_ram", ReadData, 32'h1234_AAEF);
        rd(BASE + 32'h8);  chk("stores_nochg", ReadData, 32'd3);
        st(BASE + 32'hC, 32'h0000_0001, 2'b10);
        chk("w1c_clear", {31'b0, MisalignErr}, 32'h0);
        st(32'h101, 32'h0, 2'b01);
        chk("err_reset", {31'b0, MisalignErr}, 32'h1);
        st(BASE + 32'hC, 32'hFFFF_FFFE, 2'b10);
        chk("w1c_zero", {31'b0, MisalignErr}, 32'h1);
        st(BASE + 32'hE, 32'h0000_0001, 2'b10);
        chk("w1c_misal", {31'b0, MisalignErr}, 32'h1);
        rd(BASE + 32'hC);  chk("status_rd", ReadData, 32'h1);
        st(BASE + 32'hC, 32'h0000_0001, 2'b10);
        chk("w1c_clear2", {31'b0, MisalignErr}, 32'h0);

        // GPIO and MMIO sub-word stores.
        st(BASE, 32'h5A5A_0001, 2'b10);
        chk("gpio_out", GpioOut, 32'h5A5A_0001);
        rd(BASE + 32'h1);  chk("gpio_rd", ReadData, 32'h5A5A_0001);
        st(BASE, 32'h0000_00FF, 2'b00);
        chk("gpio_byte", GpioOut, 32'h5A5A_0001);
        chk("gpio_byte_err", {31'b0, MisalignErr}, 32'h1);
        st(BASE + 32'h8, 32'h1234_5678, 2'b10);
        rd(BASE + 32'h8);  chk("stores_mmio", ReadData, 32'd3);
        rd(BASE + 32'h4);  c1 = ReadData;
        repeat (5) @(negedge clk);
        #1;
        rd(BASE + 32'h4);  c2 = ReadData;
        chk("cycle_delta", c2 - c1, 32'd5);

        // Address wrap and read-during-write.
        rd(32'h1100);      chk("wrap_rd", ReadData, 32'h1234_AAEF);
        @(negedge clk);
        AddrM       = 32'h100;
        WriteDataM  = 32'hCAFE_F00D;
        ByteAccessM = 2'b10;
        MemWriteM   = 1'b1;
        #1;
        chk("rdw_old", ReadData, 32'h1234_AAEF);
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        chk("rdw_new", ReadData, 32'hCAFE_F00D);
        rd(BASE + 32'h8);  chk("stores_4", ReadData, 32'd4);

        // Asynchronous reset in the middle of a store burst.
        st(32'h200, 32'h1111_1111, 2'b10);
        st(32'h204, 32'h3333_3333, 2'b10);
        @(negedge clk);
        AddrM       = 32'h204;
        WriteDataM  = 32'h4444_4444;
        ByteAccessM = 2'b10;
        MemWriteM   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_gpio", GpioOut, 32'h0);
        chk("arst_err", {31'b0, MisalignErr}, 32'h0);
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        rd(BASE + 32'h8);  chk("arst_stores", ReadData, 32'h0);
        rd(BASE + 32'h4);  chk("arst_cycle", ReadData, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd(32'h200);       chk("keep_200", ReadData, 32'h1111_1111);
        rd(32'h204);       chk("drop_204", ReadData, 32'h3333_3333);
        rd(32'h100);       chk("keep_100", ReadData, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
